ef_smsdac_seg_mse: RTL and testbench

Parametrised segmented first-order mismatch-shaping encoder with an integrated input register, output retiming register and optional LFSR dither.
- Splits a W-bit unsigned sample into S shaped 3-level LSB segments (weights 2^0..2^(S-1)) and one MSB remainder word (weight 2^S).
- Sits between the sample source and the weighted 3-level DAC element drivers.
- Adds a sample-enable strobe and an output valid flag.

---
 rtl/ef_smsdac_seg_mse.sv | 138 +++++++++++++
 tb/tb_ef_smsdac_seg_mse.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ef_smsdac_seg_mse.sv
// Segmented first-order mismatch-shaping encoder: S shaped 3-level LSB segments plus an MSB remainder.
// Optional LFSR tie-break dither is built when SMSDAC_DITHER_EN is defined.
module ef_smsdac_seg_mse #(
    parameter int unsigned W = 8,
    parameter int unsigned S = 3
) (
    input  logic               clk,
    input  logic               rst_b,
    input  logic               en,
    input  logic               en_dith,
    input  logic [W-1:0]       d_in,
    output logic [2*S-1:0]     d_seg,
    output logic [W-S:0]       d_msb,
    output logic               out_vld
);

    localparam int unsigned MW = W - S + 1;
    localparam int unsigned XW = W + 1;
    localparam int unsigned SW = 2 * S;
    localparam int unsigned LW = 15;

    logic [W-1:0]        d_q_q, d_q_d;
    logic [S-1:0][1:0]   integ_q, integ_d, integ_nx;
    logic [SW-1:0]       seg_q, seg_d, seg_c;
    logic [MW-1:0]       msb_q, msb_d, msb_c;
    logic                vld_q, vld_d;
    logic                dith_act;
    logic [S-1:0]        rnd;

`ifdef SMSDAC_DITHER_EN
    logic [LW-1:0]       lfsr_q, lfsr_d;

    // Fibonacci LFSR x^15+x^14+1, advancing on every enabled edge
    always_comb begin
        lfsr_d = lfsr_q;
        if (en) begin
            lfsr_d = {lfsr_q[LW-2:0], lfsr_q[14] ^ lfsr_q[13]};
        end
        dith_act = en_dith;
        rnd      = lfsr_q[S-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            lfsr_q <= LW'(1);
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    logic unused_en_dith;

    always_comb begin
        dith_act       = 1'b0;
        rnd            = '0;
        unused_en_dith = en_dith;
    end
`endif

    // Stage chain: pick s_i from parity and integrator, carry the exact quotient to the next stage.
    // Integrator code: 2'b01=+1, 2'b00=0, 2'b11=-1.
    always_comb begin
        logic [XW-1:0] x;
        logic          pos;
        logic          neg;
        x        = XW'(d_q_q);
        seg_c    = '0;
        integ_nx = integ_q;
        for (int unsigned i = 0; i < S; i++) begin
            pos = 1'b0;
            neg = 1'b0;
            if (x[0]) begin
                if (integ_q[i] == 2'b01) begin
                    neg = 1'b1;
                end else if (integ_q[i] == 2'b11) begin
                    pos = 1'b1;
                end else if (dith_act && rnd[i]) begin
                    neg = 1'b1;
                end else begin
                    pos = 1'b1;
                end
            end
            seg_c[2*i +: 2] = {pos, ~pos & ~neg};
            // x odd: (x-1)/2 = x>>1, (x+1)/2 = (x>>1)+1
            x = (x >> 1) + XW'(neg);
            if (pos) begin
                integ_nx[i] = integ_q[i] + 2'b01;
            end else if (neg) begin
                integ_nx[i] = integ_q[i] - 2'b01;
            end
        end
        msb_c = x[MW-1:0];
    end

    // Next-state: everything except out_vld holds when en=0
    always_comb begin
        d_q_d   = d_q_q;
        integ_d = integ_q;
        seg_d   = seg_q;
        msb_d   = msb_q;
        vld_d   = en;
        if (en) begin
            d_q_d   = d_in;
            integ_d = integ_nx;
            seg_d   = seg_c;
            msb_d   = msb_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            d_q_q   <= '0;
            integ_q <= '0;
            seg_q   <= {S{2'b01}};
            msb_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            d_q_q   <= d_q_d;
            integ_q <= integ_d;
            seg_q   <= seg_d;
            msb_q   <= msb_d;
            vld_q   <= vld_d;
        end
    end

    assign d_seg   = seg_q;
    assign d_msb   = msb_q;
    assign out_vld = vld_q;

    // Integrators must never leave {-1,0,+1}; output codes never 2'b11
    for (genvar g = 0; g < S; g++) begin : g_chk
        a_integ_range : assert property (@(posedge clk) disable iff (!rst_b)
            integ_q[g] != 2'b10);
        a_seg_code : assert property (@(posedge clk) disable iff (!rst_b)
            seg_q[2*g +: 2] != 2'b11);
    end

endmodule

// File: tb/tb_ef_smsdac_seg_mse.sv
// Scoreboard bench for ef_smsdac_seg_mse: arithmetic reference model feeds a queue, a monitor pops on out_vld.
module tb_ef_smsdac_seg_mse;

    localparam int unsigned W  = 8;
    localparam int unsigned S  = 3;
    localparam int unsigned MW = W - S + 1;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             en;
    logic             en_dith;
    logic [W-1:0]     d_in;
    logic [2*S-1:0]   d_seg;
    logic [MW-1:0]    d_msb;
    logic             out_vld;

    always #5 clk = ~clk;

    ef_smsdac_seg_mse #(.W(W), .S(S)) dut (
        .clk     (clk),
        .rst_b   (rst_b),
        .en      (en),
        .en_dith (en_dith),
        .d_in    (d_in),
        .d_seg   (d_seg),
        .d_msb   (d_msb),
        .out_vld (out_vld)
    );

    typedef struct {
        logic [2*S-1:0] seg;
        logic [MW-1:0]  msb;
        int             sample;
    } exp_t;

    exp_t           sb_q[$];
    int             n_cmp = 0;
    int             n_bad = 0;
    int             m_dq;
    int             m_int[S];
    int             m_lfsr;
    bit             exp_vld;
    bit             started = 1'b0;
    logic [2*S-1:0] hold_seg;
    logic [MW-1:0]  hold_msb;

    // One clock of stimulus; the model advances in lockstep with what the DUT sees at the next edge
    task automatic cyc(input bit rb, input bit e, input int din, input bit dith);
        exp_t ent;
        int   x;
        int   s;
        int   r;
        @(negedge clk);
        rst_b   = rb;
        en      = e;
        d_in    = W'(din);
        en_dith = dith;
        started = 1'b1;
        if (!rb) begin
            m_dq = 0;
            foreach (m_int[i]) m_int[i] = 0;
            m_lfsr   = 1;
            exp_vld  = 1'b0;
            hold_seg = {S{2'b01}};
            hold_msb = '0;
        end else begin
            exp_vld = e;
            if (e) begin
                x          = m_dq;
                ent.sample = m_dq;
                ent.seg    = '0;
                for (int i = 0; i < S; i++) begin
                    r = (m_lfsr >> i) & 1;
                    if (x % 2 == 0) s = 0;
                    else if (m_int[i] == 1) s = -1;
                    else if (m_int[i] == -1) s = 1;
`ifdef SMSDAC_DITHER_EN
                    else s = dith ? -(2 * r - 1) : 1;
`else
                    else s = 1;
`endif
                    x = (x - s) / 2;
                    m_int[i] += s;
                    ent.seg[2*i +: 2] = 2'(s + 1);
                end
                ent.msb  = MW'(x);
                hold_seg = ent.seg;
                hold_msb = ent.msb;
                sb_q.push_back(ent);
                m_dq   = din;
                m_lfsr = ((m_lfsr << 1) | (((m_lfsr >> 14) ^ (m_lfsr >> 13)) & 1)) & 32'h7fff;
            end
        end
    endtask

    function automatic int recon(input logic [2*S-1:0] seg, input logic [MW-1:0] msb);
        int          v;
        logic [1:0]  c;
        v = int'(msb) * (1 << S);
        for (int i = 0; i < S; i++) begin
            c = seg[2*i +: 2];
            if (c == 2'b11) return -100000;
            v += (int'(c) - 1) * (1 << i);
        end
        return v;
    endfunction

    // Monitor: samples 1 time unit after each active edge
    always @(posedge clk) begin
        exp_t ent;
        int   rec;
        #1;
        if (started) begin
            n_cmp++;
            if (out_vld !== exp_vld) begin
                n_bad++;
                $display("FAIL out_vld t=%0t got=%b want=%b", $time, out_vld, exp_vld);
            end
            if (out_vld === 1'b1) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_empty t=%0t got=valid want=no_output", $time);
                end else begin
                    ent = sb_q.pop_front();
                    if (d_seg !== ent.seg || d_msb !== ent.msb) begin
                        n_bad++;
                        $display("FAIL code t=%0t got=%b/%0d want=%b/%0d",
                                 $time, d_seg, d_msb, ent.seg, ent.msb);
                    end
                    n_cmp++;
                    rec = recon(d_seg, d_msb);
                    if (rec != ent.sample) begin
                        n_bad++;
                        $display("FAIL recon t=%0t got=%0d want=%0d", $time, rec, ent.sample);
                    end
                end
            end else begin
                n_cmp++;
                if (d_seg !== hold_seg || d_msb !== hold_msb) begin
                    n_bad++;
                    $display("FAIL hold t=%0t got=%b/%0d want=%b/%0d",
                             $time, d_seg, d_msb, hold_seg, hold_msb);
                end
            end
        end
    end

    initial begin
        rst_b   = 1'b0;
        en      = 1'b0;
        en_dith = 1'b0;
        d_in    = '0;

        // Reset held 3 cycles with en=1, then idle zeros
        repeat (3) cyc(1'b0, 1'b1, 0, 1'b0);
        repeat (4) cyc(1'b1, 1'b1, 0, 1'b0);

        // Constant 1 from clean integrators
        cyc(1'b0, 1'b1, 0, 1'b0);
        repeat (9) cyc(1'b1, 1'b1, 1, 1'b0);

        // Full scale 255
        cyc(1'b0, 1'b1, 0, 1'b0);
        repeat (6) cyc(1'b1, 1'b1, 255, 1'b0);

        // Ones with 5-cycle stalls between samples
        cyc(1'b0, 1'b1, 0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, 1, 1'b0);
            repeat (5) cyc(1'b1, 1'b0, 1, 1'b0);
        end
        repeat (2) cyc(1'b1, 1'b1, 1, 1'b0);

        // Reset after the first encoded sample of constant 1
        cyc(1'b0, 1'b1, 0, 1'b0);
        repeat (2) cyc(1'b1, 1'b1, 1, 1'b0);
        cyc(1'b0, 1'b1, 1, 1'b0);
        repeat (5) cyc(1'b1, 1'b1, 1, 1'b0);

        // Randomized traffic with stalls, dither toggling and rare resets
        for (int k = 0; k < 20000; k++) begin
            cyc(($urandom % 300) != 0, ($urandom % 6) != 0,
                int'($urandom_range(0, (1 << W) - 1)), 1'($urandom % 4 != 0));
        end

        // Drain, then stall and confirm nothing is left unclaimed
        repeat (3) cyc(1'b1, 1'b1, 0, 1'b0);
        repeat (2) cyc(1'b1, 1'b0, 0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL sb_leftover got=%0d want=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
